// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and forward-select helper for the hazard unit
// Forward mux codes and the multi-cycle wait FSM state type.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // The newer MEM-stage value wins over WB when both write the same register.
  function automatic logic [1:0] fwd_sel(input logic hit_mem, input logic hit_wb);
    if (hit_mem) return FWD_MEM;
    if (hit_wb)  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline-to-hazard-unit signal bundle
// The master side is the pipeline datapath, the slave side is the hazard unit.
interface hazard_unit_if #(
  parameter int sizeAd = 5,
  parameter int CNTW   = 16
);
  logic [sizeAd-1:0] RsD, RtD, RsE, RtE;
  logic [sizeAd-1:0] WriteRegE, WriteRegM, WriteRegW;
  logic              RFWEE, RFWEM, RFWEW;
  logic              MtoRFSelE, MtoRFSelM;
  logic              BranchD, MDStartE;
  logic              StallF, StallD, FlushE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              ForwardAD, ForwardBD;
  logic [CNTW-1:0]   StallCount, FlushCount;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RFWEE, RFWEM, RFWEW, MtoRFSelE, MtoRFSelM, BranchD, MDStartE,
    input  StallF, StallD, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallCount, FlushCount
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RFWEE, RFWEM, RFWEW, MtoRFSelE, MtoRFSelM, BranchD, MDStartE,
    output StallF, StallD, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallCount, FlushCount
  );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
// Counts cycles with inc high and holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - MIPS 5-stage hazard detection, forwarding and mult/div wait control
// Forwarding and stall decisions are combinational; only the mult/div wait FSM and counters hold state.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int sizeAd    = 5,
  parameter int MD_CYCLES = 4,
  parameter int CNTW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_unit_if.slave  hz
);

  localparam int              MDW      = $clog2(MD_CYCLES) + 1;
  localparam bit              MD_MULTI = (MD_CYCLES > 1);
  localparam logic [MDW-1:0]  MD_LOAD  = MDW'(MD_MULTI ? MD_CYCLES - 2 : 0);
  localparam logic [sizeAd-1:0] REG0   = '0;

  md_state_t      r_state, w_state_nxt;
  logic [MDW-1:0] r_mdcnt, w_mdcnt_nxt;
  logic           w_wm_valid, w_ww_valid, w_we_valid, w_lm_valid;
  logic           w_lwstall, w_branchstall, w_md_stall, w_stall;

  // A writer targeting $0 never produces a hazard, so gate it out once here.
  assign w_wm_valid = hz.RFWEM     && (hz.WriteRegM != REG0);
  assign w_ww_valid = hz.RFWEW     && (hz.WriteRegW != REG0);
  assign w_we_valid = hz.RFWEE     && (hz.WriteRegE != REG0);
  assign w_lm_valid = hz.MtoRFSelM && (hz.WriteRegM != REG0);

  assign w_lwstall = hz.MtoRFSelE && (hz.RtE != REG0) &&
                     ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));

  assign w_branchstall = hz.BranchD &&
      ((w_we_valid && ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD))) ||
       (w_lm_valid && ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD))));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_mdcnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mdcnt <= w_mdcnt_nxt;
    end
  end

  // The start cycle already stalls, so the busy phase ends as the count reaches zero.
  always_comb begin
    w_state_nxt = r_state;
    w_mdcnt_nxt = r_mdcnt;
    case (r_state)
      IDLE: begin
        if (hz.MDStartE && MD_MULTI) begin
          w_state_nxt = MD_BUSY;
          w_mdcnt_nxt = MD_LOAD;
        end
      end
      MD_BUSY: begin
        if (r_mdcnt <= MDW'(1)) begin
          w_state_nxt = IDLE;
          w_mdcnt_nxt = '0;
        end else begin
          w_mdcnt_nxt = r_mdcnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_mdcnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_md_stall = (r_state == MD_BUSY) ||
                 ((r_state == IDLE) && hz.MDStartE && MD_MULTI);
  end

  assign w_stall = rst && (w_lwstall || w_branchstall || w_md_stall);

  always_comb begin
    hz.StallF    = w_stall;
    hz.StallD    = w_stall;
    hz.FlushE    = w_stall;
    hz.ForwardAE = FWD_RF;
    hz.ForwardBE = FWD_RF;
    hz.ForwardAD = 1'b0;
    hz.ForwardBD = 1'b0;
    if (rst) begin
      hz.ForwardAE = fwd_sel(w_wm_valid && (hz.WriteRegM == hz.RsE),
                             w_ww_valid && (hz.WriteRegW == hz.RsE));
      hz.ForwardBE = fwd_sel(w_wm_valid && (hz.WriteRegM == hz.RtE),
                             w_ww_valid && (hz.WriteRegW == hz.RtE));
      hz.ForwardAD = w_wm_valid && (hz.WriteRegM == hz.RsD);
      hz.ForwardBD = w_wm_valid && (hz.WriteRegM == hz.RtD);
    end
  end

  sat_counter #(.W(CNTW)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hz.StallD),
    .count (hz.StallCount)
  );

  sat_counter #(.W(CNTW)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hz.FlushE),
    .count (hz.FlushCount)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
// Three instances (MD_CYCLES=4, MD_CYCLES=1, CNTW=4) share one stimulus stream.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] RsD, RtD, RsE, RtE, WrE, WrM, WrW;
  logic       RFWEE, RFWEM, RFWEW, MtoE, MtoM, BrD, MDS;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  hazard_unit_if #(.sizeAd(5), .CNTW(16)) if0 ();
  hazard_unit_if #(.sizeAd(5), .CNTW(16)) if1 ();
  hazard_unit_if #(.sizeAd(5), .CNTW(4))  if2 ();

  hazard_unit #(.sizeAd(5), .MD_CYCLES(4), .CNTW(16)) u0 (.clk(clk), .rst(rst), .hz(if0));
  hazard_unit #(.sizeAd(5), .MD_CYCLES(1), .CNTW(16)) u1 (.clk(clk), .rst(rst), .hz(if1));
  hazard_unit #(.sizeAd(5), .MD_CYCLES(4), .CNTW(4))  u2 (.clk(clk), .rst(rst), .hz(if2));

  assign if0.RsD = RsD;         assign if1.RsD = RsD;         assign if2.RsD = RsD;
  assign if0.RtD = RtD;         assign if1.RtD = RtD;         assign if2.RtD = RtD;
  assign if0.RsE = RsE;         assign if1.RsE = RsE;         assign if2.RsE = RsE;
  assign if0.RtE = RtE;         assign if1.RtE = RtE;         assign if2.RtE = RtE;
  assign if0.WriteRegE = WrE;   assign if1.WriteRegE = WrE;   assign if2.WriteRegE = WrE;
  assign if0.WriteRegM = WrM;   assign if1.WriteRegM = WrM;   assign if2.WriteRegM = WrM;
  assign if0.WriteRegW = WrW;   assign if1.WriteRegW = WrW;   assign if2.WriteRegW = WrW;
  assign if0.RFWEE = RFWEE;     assign if1.RFWEE = RFWEE;     assign if2.RFWEE = RFWEE;
  assign if0.RFWEM = RFWEM;     assign if1.RFWEM = RFWEM;     assign if2.RFWEM = RFWEM;
  assign if0.RFWEW = RFWEW;     assign if1.RFWEW = RFWEW;     assign if2.RFWEW = RFWEW;
  assign if0.MtoRFSelE = MtoE;  assign if1.MtoRFSelE = MtoE;  assign if2.MtoRFSelE = MtoE;
  assign if0.MtoRFSelM = MtoM;  assign if1.MtoRFSelM = MtoM;  assign if2.MtoRFSelM = MtoM;
  assign if0.BranchD = BrD;     assign if1.BranchD = BrD;     assign if2.BranchD = BrD;
  assign if0.MDStartE = MDS;    assign if1.MDStartE = MDS;    assign if2.MDStartE = MDS;

  // Model: bubbles still owed to a mult/div op, and plain integer event counts.
  int md_cyc[3]  = '{4, 1, 4};
  int cnt_max[3] = '{65535, 65535, 15};
  int md_left[3] = '{0, 0, 0};
  int m_cnt[3]   = '{0, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic bit reads_d(input logic [4:0] r);
    return (r != 0) && ((r == RsD) || (r == RtD));
  endfunction

  function automatic bit m_stall(input int k);
    bit lw, br, md;
    if (!rst) return 1'b0;
    lw = MtoE && (RtE != 0) && ((RtE == RsD) || (RtE == RtD));
    br = BrD && ((RFWEE && reads_d(WrE)) || (MtoM && reads_d(WrM)));
    md = (md_left[k] > 0) || (MDS && md_cyc[k] > 1);
    return lw || br || md;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (!rst || src == 0) return 2'd0;
    if (RFWEM && WrM == src) return 2'd2;
    if (RFWEW && WrW == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic m_fwd_d(input logic [4:0] src);
    return rst && (src != 0) && RFWEM && (WrM == src);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        md_left[k] = 0;
        m_cnt[k]   = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (m_stall(k) && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
        if (md_left[k] > 0) md_left[k]--;
        else if (MDS && md_cyc[k] > 1) md_left[k] = md_cyc[k] - 2;
      end
    end
  end

  task automatic cmp(input int k, input logic sf, input logic sd, input logic fe,
                     input logic [1:0] fae, input logic [1:0] fbe, input logic fad,
                     input logic fbd, input logic [15:0] sc, input logic [15:0] fc);
    bit s;
    s = m_stall(k);
    chk($sformatf("u%0d_StallF", k), sf, s);
    chk($sformatf("u%0d_StallD", k), sd, s);
    chk($sformatf("u%0d_FlushE", k), fe, s);
    chk($sformatf("u%0d_ForwardAE", k), fae, m_fwd(RsE));
    chk($sformatf("u%0d_ForwardBE", k), fbe, m_fwd(RtE));
    chk($sformatf("u%0d_ForwardAD", k), fad, m_fwd_d(RsD));
    chk($sformatf("u%0d_ForwardBD", k), fbd, m_fwd_d(RtD));
    chk($sformatf("u%0d_StallCount", k), sc, m_cnt[k]);
    chk($sformatf("u%0d_FlushCount", k), fc, m_cnt[k]);
  endtask

  always @(negedge clk) begin
    cmp(0, if0.StallF, if0.StallD, if0.FlushE, if0.ForwardAE, if0.ForwardBE,
        if0.ForwardAD, if0.ForwardBD, if0.StallCount, if0.FlushCount);
    cmp(1, if1.StallF, if1.StallD, if1.FlushE, if1.ForwardAE, if1.ForwardBE,
        if1.ForwardAD, if1.ForwardBD, if1.StallCount, if1.FlushCount);
    cmp(2, if2.StallF, if2.StallD, if2.FlushE, if2.ForwardAE, if2.ForwardBE,
        if2.ForwardAD, if2.ForwardBD, {12'd0, if2.StallCount}, {12'd0, if2.FlushCount});
  end

  task automatic clear_in();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0; WrE = 0; WrM = 0; WrW = 0;
    RFWEE = 0; RFWEM = 0; RFWEW = 0; MtoE = 0; MtoM = 0; BrD = 0; MDS = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  initial begin
    clear_in();
    RsE = 3; RFWEM = 1; WrM = 3; MtoE = 1; RtE = 2; RsD = 2;
    samp();
    chk("rst_ForwardAE", if0.ForwardAE, 2'b00);
    chk("rst_StallD", if0.StallD, 1'b0);
    chk("rst_StallCount", if0.StallCount, 0);
    tick(); rst = 1;
    samp();
    chk("rel_ForwardAE", if0.ForwardAE, 2'b10);
    chk("rel_StallD", if0.StallD, 1'b1);
    tick(); clear_in();
    samp();
    chk("rel_StallCount", if0.StallCount, 1);

    RsE = 5; WrM = 5; WrW = 5; RFWEM = 1; RFWEW = 1;
    samp(); chk("fwd_mem_prio", if0.ForwardAE, 2'b10);
    tick(); RFWEM = 0;
    samp(); chk("fwd_wb", if0.ForwardAE, 2'b01);
    tick(); RsE = 0;
    samp(); chk("fwd_r0", if0.ForwardAE, 2'b00);
    tick(); clear_in(); RtE = 6; WrW = 6; RFWEW = 1;
    samp(); chk("fwdB_wb", if0.ForwardBE, 2'b01);

    tick(); clear_in(); rst = 0;
    tick(); rst = 1;
    MtoE = 1; RtE = 7; RsD = 7;
    samp();
    chk("lw_StallF", if0.StallF, 1'b1);
    chk("lw_FlushE", if0.FlushE, 1'b1);
    chk("lw_cnt_before", if0.StallCount, 0);
    tick(); clear_in();
    samp();
    chk("lw_release", if0.StallD, 1'b0);
    chk("lw_StallCount", if0.StallCount, 1);
    chk("lw_FlushCount", if0.FlushCount, 1);

    tick(); BrD = 1; RFWEE = 1; WrE = 9; RtD = 9;
    samp(); chk("br_ex", if0.StallD, 1'b1);
    tick(); RFWEE = 0; MtoM = 1; WrM = 9;
    samp(); chk("br_mem_load", if0.StallD, 1'b1);
    tick(); MtoM = 0;
    samp(); chk("br_no_dep", if0.StallD, 1'b0);
    tick(); BrD = 0; RFWEE = 1; WrE = 9; MtoM = 1;
    samp(); chk("no_branch", if0.StallD, 1'b0);
    tick(); clear_in(); RFWEM = 1; WrM = 9; RtD = 9;
    samp();
    chk("fwd_BD", if0.ForwardBD, 1'b1);
    chk("fwd_AD", if0.ForwardAD, 1'b0);

    tick(); clear_in(); MDS = 1;
    samp();
    chk("md_start", if0.StallD, 1'b1);
    chk("md1_nostall", if1.StallD, 1'b0);
    tick(); MDS = 0;
    for (int i = 1; i < 5; i++) begin
      samp();
      chk($sformatf("md_seq%0d", i), if0.StallD, (i < 3) ? 1'b1 : 1'b0);
      tick();
    end
    MDS = 1;
    samp(); chk("md2_c0", if0.StallD, 1'b1);
    tick(); MDS = 1;
    samp(); chk("md2_c1", if0.StallD, 1'b1);
    tick(); MDS = 0;
    samp(); chk("md2_c2", if0.StallD, 1'b1);
    tick();
    samp(); chk("md2_noext", if0.StallD, 1'b0);

    tick(); MDS = 1;
    tick(); MDS = 0;
    tick(); rst = 0;
    samp();
    chk("abort_stall", if0.StallD, 1'b0);
    chk("abort_cnt", if0.StallCount, 0);
    tick(); rst = 1;
    samp(); chk("abort_idle", if0.StallD, 1'b0);

    tick(); MtoE = 1; RtE = 7; RsD = 7;
    repeat (20) tick();
    clear_in();
    samp();
    chk("sat_w4", if2.StallCount, 4'd15);
    chk("sat_w4_flush", if2.FlushCount, 4'd15);
    chk("nosat_w16", if0.StallCount, 20);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
